// File: rtl/pc_unit.sv
// Program counter unit: holds the fetch address and selects the next one from
// reset, trap entry, trap return, redirect, stall or sequential increment.
// Includes a saved exception PC, misaligned-target detection and a debug
// RUN / TRAP_FLUSH / HALT state machine.
//
// Optional feature: define PC_HISTORY_EN to instantiate a circular buffer of
// the last HIST_DEPTH departing fetch addresses, readable through hist_idx /
// hist_pc. Without it hist_pc is tied to zero and no storage exists.

module pc_unit #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = '0,
  parameter logic [XLEN-1:0] TRAP_VEC    = 'h100,
  parameter int unsigned     INSTR_BYTES = 4,
  parameter int unsigned     HIST_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          stall,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  input  logic                          trap_req,
  input  logic                          mret,
  input  logic                          halt_req,
  input  logic                          resume_req,
  output logic [XLEN-1:0]               instr_addr,
  output logic                          instr_valid,
  output logic [XLEN-1:0]               epc,
  output logic                          misaligned,
  output logic                          halted,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
  output logic [XLEN-1:0]               hist_pc
);

  localparam int unsigned     HistAw    = $clog2(HIST_DEPTH);
  localparam logic [XLEN-1:0] AlignMask = XLEN'(INSTR_BYTES - 1);
  localparam logic [XLEN-1:0] PcStep    = XLEN'(INSTR_BYTES);

  typedef enum logic [1:0] {
    StRun,
    StTrapFlush,
    StHalt
  } state_e;

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] epc_q;
  logic            valid_q;
  logic            halted_q;
  logic            misaligned_q;

  logic            redirect_misaligned;

  // Target alignment check against the instruction size.
  assign redirect_misaligned = (redirect_pc & AlignMask) != '0;

  // Main FSM: next PC, epc and all status outputs are registered here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StRun;
      pc_q         <= RESET_VEC;
      epc_q        <= '0;
      valid_q      <= 1'b1;
      halted_q     <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      // Misaligned is a single-cycle pulse unless re-detected below.
      misaligned_q <= 1'b0;
      case (state_q)
        StRun: begin
          if (trap_req) begin
            epc_q   <= pc_q;
            pc_q    <= TRAP_VEC;
            state_q <= StTrapFlush;
            valid_q <= 1'b0;
          end else if (redirect_valid && redirect_misaligned) begin
            misaligned_q <= 1'b1;
            epc_q        <= redirect_pc;
            pc_q         <= TRAP_VEC;
            state_q      <= StTrapFlush;
            valid_q      <= 1'b0;
          end else if (mret) begin
            pc_q <= epc_q;
          end else if (redirect_valid) begin
            pc_q <= redirect_pc;
          end else if (halt_req) begin
            state_q  <= StHalt;
            valid_q  <= 1'b0;
            halted_q <= 1'b1;
          end else if (!stall) begin
            // Wraps modulo 2^XLEN by construction.
            pc_q <= pc_q + PcStep;
          end
        end

        // One bubble cycle at TRAP_VEC; only a halt request is honoured.
        StTrapFlush: begin
          if (halt_req) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end else begin
            state_q <= StRun;
            valid_q <= 1'b1;
          end
        end

        StHalt: begin
          // Debugger may set the PC; a misaligned write is dropped but flagged.
          if (redirect_valid) begin
            if (redirect_misaligned) begin
              misaligned_q <= 1'b1;
            end else begin
              pc_q <= redirect_pc;
            end
          end
          if (resume_req) begin
            state_q  <= StRun;
            valid_q  <= 1'b1;
            halted_q <= 1'b0;
          end
        end

        default: begin
          state_q  <= StRun;
          valid_q  <= 1'b1;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  assign instr_addr  = pc_q;
  assign instr_valid = valid_q;
  assign epc         = epc_q;
  assign misaligned  = misaligned_q;
  assign halted      = halted_q;

`ifdef PC_HISTORY_EN
  logic [XLEN-1:0]   hist_mem [HIST_DEPTH];
  logic [HistAw-1:0] hist_wptr_q;
  logic [HistAw-1:0] hist_ridx;
  logic              hist_we;

  // The PC departs from a valid fetch whenever RUN does anything but hold.
  always_comb begin
    hist_we = (state_q == StRun) &&
              (trap_req || redirect_valid || mret || (!halt_req && !stall));
  end

  // Write pointer; wraps naturally since HIST_DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_wptr_q <= '0;
    end else if (hist_we) begin
      hist_wptr_q <= hist_wptr_q + HistAw'(1);
    end
  end

  // History storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (hist_we) begin
      hist_mem[hist_wptr_q] <= pc_q;
    end
  end

  // hist_idx = 0 selects the most recently written entry.
  assign hist_ridx = hist_wptr_q - HistAw'(1) - hist_idx;
  assign hist_pc   = hist_mem[hist_ridx];
`else
  logic unused_hist_idx;
  assign unused_hist_idx = ^hist_idx;
  assign hist_pc         = '0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit with default parameters.

module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, redirect_valid, trap_req, mret, halt_req, resume_req;
  logic [31:0] redirect_pc;
  logic [31:0] instr_addr, epc, hist_pc;
  logic        instr_valid, misaligned, halted;
  logic [2:0]  hist_idx;

  int n_tests = 0;
  int n_fail  = 0;

  pc_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_req       (trap_req),
    .mret           (mret),
    .halt_req       (halt_req),
    .resume_req     (resume_req),
    .instr_addr     (instr_addr),
    .instr_valid    (instr_valid),
    .epc            (epc),
    .misaligned     (misaligned),
    .halted         (halted),
    .hist_idx       (hist_idx),
    .hist_pc        (hist_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; redirect_valid = 0; redirect_pc = '0; trap_req = 0;
    mret = 0; halt_req = 0; resume_req = 0;
  endtask

  task automatic chk_state(input string tag, input logic [31:0] pc, input logic v,
                           input logic h, input logic m);
    check({tag, ".pc"}, instr_addr, pc);
    check({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, v});
    check({tag, ".halted"}, {31'd0, halted}, {31'd0, h});
    check({tag, ".mis"}, {31'd0, misaligned}, {31'd0, m});
  endtask

  initial begin
    idle_inputs();
    hist_idx = '0;
    reset_n  = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 32'h0, 1, 0, 0);
    check("reset.epc", epc, 32'h0);
    reset_n = 1;

    // Sequential fetch
    step(); chk_state("seq1", 32'h4, 1, 0, 0);
    step(); chk_state("seq2", 32'h8, 1, 0, 0);

    // Stall, then redirect overriding stall
    stall = 1;
    step(); chk_state("stall1", 32'h8, 1, 0, 0);
    step(); chk_state("stall2", 32'h8, 1, 0, 0);
    redirect_valid = 1; redirect_pc = 32'h40;
    step(); chk_state("redir_stall", 32'h40, 1, 0, 0);
    idle_inputs();
    step(); chk_state("seq44", 32'h44, 1, 0, 0);

    // Trap entry, flush bubble, resume at TRAP_VEC, mret
    trap_req = 1; stall = 1;
    step(); chk_state("trap", 32'h100, 0, 0, 0);
    check("trap.epc", epc, 32'h44);
    idle_inputs();
    step(); chk_state("flush_done", 32'h100, 1, 0, 0);
    step(); chk_state("trap_seq", 32'h104, 1, 0, 0);
    mret = 1;
    step(); chk_state("mret", 32'h44, 1, 0, 0);
    idle_inputs();

    // Misaligned redirect
    redirect_valid = 1; redirect_pc = 32'h10;
    step(); chk_state("redir10", 32'h10, 1, 0, 0);
    redirect_pc = 32'h42;
    step(); chk_state("misal", 32'h100, 0, 0, 1);
    check("misal.epc", epc, 32'h42);
    idle_inputs();
    step(); chk_state("misal_end", 32'h100, 1, 0, 0);

    // Halt, ignored trap/stall, debugger PC write, resume
    redirect_valid = 1; redirect_pc = 32'h20;
    step(); chk_state("redir20", 32'h20, 1, 0, 0);
    idle_inputs(); halt_req = 1;
    step(); chk_state("halt", 32'h20, 0, 1, 0);
    idle_inputs(); trap_req = 1; stall = 1; mret = 1;
    step(); chk_state("halt_ign", 32'h20, 0, 1, 0);
    check("halt_ign.epc", epc, 32'h42);
    idle_inputs(); redirect_valid = 1; redirect_pc = 32'h80;
    step(); chk_state("halt_redir", 32'h80, 0, 1, 0);
    redirect_pc = 32'h83;
    step(); chk_state("halt_misal", 32'h80, 0, 1, 1);
    check("halt_misal.epc", epc, 32'h42);
    idle_inputs(); resume_req = 1;
    step(); chk_state("resume", 32'h80, 1, 0, 0);
    idle_inputs();
    step(); chk_state("resume_seq", 32'h84, 1, 0, 0);

    // Resume together with a redirect: both take effect
    halt_req = 1;
    step(); chk_state("halt2", 32'h84, 0, 1, 0);
    idle_inputs(); resume_req = 1; redirect_valid = 1; redirect_pc = 32'hA0;
    step(); chk_state("resume_redir", 32'hA0, 1, 0, 0);

    // Trap flush followed by a halt request
    idle_inputs(); trap_req = 1;
    step(); chk_state("trap2", 32'h100, 0, 0, 0);
    check("trap2.epc", epc, 32'hA0);
    idle_inputs(); halt_req = 1;
    step(); chk_state("flush_halt", 32'h100, 0, 1, 0);

    // Asynchronous reset between clock edges while halted
    idle_inputs();
    @(negedge clk);
    reset_n = 0;
    #1;
    chk_state("async_rst", 32'h0, 1, 0, 0);
    check("async_rst.epc", epc, 32'h0);
    @(posedge clk); #1;
    reset_n = 1;

    // Wrap-around and history
    for (int i = 0; i < 10; i++) step();
    check("ten_fetch", instr_addr, 32'h28);
`ifdef PC_HISTORY_EN
    hist_idx = 3'd0; #1; check("hist0", hist_pc, 32'h24);
    hist_idx = 3'd7; #1; check("hist7", hist_pc, 32'h08);
`else
    hist_idx = 3'd5; #1; check("hist_off", hist_pc, 32'h0);
`endif
    redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC;
    step(); chk_state("near_top", 32'hFFFF_FFFC, 1, 0, 0);
    idle_inputs();
    step(); chk_state("wrap", 32'h0, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
